// File: rtl/sram_ctrl.sv
// Handshaked controller for an asynchronous 16-bit SRAM: read, full write and
// byte-masked read-modify-write cycles with programmable strobe and turnaround widths.
module sram_ctrl #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ADR,
  output logic [DATA_W-1:0] dat_out,
  output logic              dat_oe,
  input  logic [DATA_W-1:0] dat_in,
  output logic              RAMCS,
  output logic              RAMOE,
  output logic              RAMWE
);

  // One counter serves both the strobe phase and the turnaround phase.
  localparam int unsigned MAX_CYC   = (WAIT_CYCLES > TURN_CYCLES) ? WAIT_CYCLES : TURN_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR       = 3'd3,
    WR_HOLD  = 3'd4,
    TURN     = 3'd5
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rmw_q;
  logic [DATA_W-1:0] merged_c;

  // Enabled lanes take the new write data, the others keep the word read back.
  assign merged_c = {be_q[1] ? wdata_q[15:8] : dat_in[15:8],
                     be_q[0] ? wdata_q[7:0]  : dat_in[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rmw_q     <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ADR       <= '0;
      dat_out   <= '0;
      dat_oe    <= 1'b0;
      RAMCS     <= 1'b1;
      RAMOE     <= 1'b1;
      RAMWE     <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            ADR       <= req_addr;
            be_q      <= req_be;
            wdata_q   <= req_wdata;
            rmw_q     <= 1'b0;
            if (!req_we || req_be == 2'b01 || req_be == 2'b10) begin
              // Partial writes start with a read of the current word.
              state <= RD;
              cnt   <= WAIT_LOAD;
              rmw_q <= req_we;
              RAMCS <= 1'b0;
              RAMOE <= 1'b0;
            end else if (req_be == 2'b11) begin
              state   <= WR_SETUP;
              RAMCS   <= 1'b0;
              dat_oe  <= 1'b1;
              dat_out <= req_wdata;
            end else begin
              state     <= TURN;
              cnt       <= TURN_LOAD;
              rsp_valid <= 1'b1;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            RAMOE <= 1'b1;
            if (rmw_q) begin
              state   <= WR_SETUP;
              dat_out <= merged_c;
              dat_oe  <= 1'b1;
            end else begin
              state     <= TURN;
              cnt       <= TURN_LOAD;
              rsp_rdata <= dat_in;
              rsp_valid <= 1'b1;
              RAMCS     <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_SETUP: begin
          state <= WR;
          cnt   <= WAIT_LOAD;
          RAMWE <= 1'b0;
        end
        WR: begin
          if (cnt == '0) begin
            state <= WR_HOLD;
            RAMWE <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_HOLD: begin
          state     <= TURN;
          cnt       <= TURN_LOAD;
          rsp_valid <= 1'b1;
          RAMCS     <= 1'b1;
          dat_oe    <= 1'b0;
        end
        TURN: begin
          if (cnt == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          RAMCS  <= 1'b1;
          RAMOE  <= 1'b1;
          RAMWE  <= 1'b1;
          dat_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (W/T = 2/1, 1/3, 4/3) against an SRAM model
// and a transaction-level reference of memory contents, latencies and strobe widths.
module tb_sram_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 16;

  function automatic int unsigned wc_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  function automatic int unsigned tc_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid [N];
  logic          req_ready [N];
  logic          req_we    [N];
  logic [1:0]    req_be    [N];
  logic [AW-1:0] req_addr  [N];
  logic [DW-1:0] req_wdata [N];
  logic          rsp_valid [N];
  logic [DW-1:0] rsp_rdata [N];
  logic [AW-1:0] adr       [N];
  logic [DW-1:0] dat_out   [N];
  logic          dat_oe    [N];
  logic [DW-1:0] dat_in    [N];
  logic          ramcs     [N];
  logic          ramoe     [N];
  logic          ramwe     [N];

  logic [DW-1:0] sram    [logic [AW+1:0]];
  logic [DW-1:0] ref_mem [logic [AW+1:0]];
  logic [DW-1:0] exp_rdata [N];
  int unsigned   inv_bad [N];
  int            n_pass  = 0;
  int            n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    sram_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(wc_of(g)), .TURN_CYCLES(tc_of(g))
    ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_be(req_be[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .ADR(adr[g]), .dat_out(dat_out[g]), .dat_oe(dat_oe[g]), .dat_in(dat_in[g]),
      .RAMCS(ramcs[g]), .RAMOE(ramoe[g]), .RAMWE(ramwe[g])
    );
  end

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(a) ^ 16'hA5C3;
  endfunction

  function automatic logic [DW-1:0] sram_rd(input int i, input logic [AW-1:0] a);
    logic [AW+1:0] k;
    k = {2'(i), a};
    return sram.exists(k) ? sram[k] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int i, input logic [AW-1:0] a);
    logic [AW+1:0] k;
    k = {2'(i), a};
    return ref_mem.exists(k) ? ref_mem[k] : init_val(a);
  endfunction

  // SRAM array: captures DAT on every clock edge that ends a WE-low cycle.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (!ramcs[i] && !ramwe[i] && dat_oe[i])
        sram[{2'(i), adr[i]}] = dat_out[i];

  // Read data path and bus invariants, evaluated mid-cycle.
  always @(negedge clk)
    for (int i = 0; i < N; i++) begin
      dat_in[i] <= (!ramcs[i] && !ramoe[i]) ? sram_rd(i, adr[i]) : 16'hDEAD;
      if ((!ramoe[i] && !ramwe[i]) || (dat_oe[i] && !ramoe[i]) ||
          (!ramoe[i] && ramcs[i]) || (!ramwe[i] && ramcs[i]) ||
          (rsp_valid[i] && req_ready[i]))
        inv_bad[i] <= inv_bad[i] + 1;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One request on instance i, checked against the transaction-level expectations.
  task automatic txn(input int i, input bit we, input logic [1:0] be,
                     input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int unsigned w, t, k, rsp_at, rdy_at, n_rsp, n_oe, n_we, n_doe, bad_adr, bad_dat;
    int unsigned e_lat, e_oe, e_we, e_doe;
    logic [DW-1:0] old, nw;
    string tg;
    w = wc_of(i); t = tc_of(i);
    tg = $sformatf("i%0d %s be%0b a%0h", i, we ? "wr" : "rd", be, a);
    k = 0;
    while (!req_ready[i] && k < 50) begin @(negedge clk); k++; end
    check({tg, " ready"}, 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1; req_we[i] = we; req_be[i] = be; req_addr[i] = a; req_wdata[i] = wd;
    @(posedge clk); #1;
    req_valid[i] = 1'b0; req_we[i] = 1'($urandom); req_be[i] = 2'($urandom);
    req_addr[i] = AW'($urandom); req_wdata[i] = DW'($urandom);
    old = ref_rd(i, a);
    nw  = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    rsp_at = 0; rdy_at = 0; n_rsp = 0; n_oe = 0; n_we = 0; n_doe = 0; bad_adr = 0; bad_dat = 0;
    for (int c = 1; c <= 60 && rdy_at == 0; c++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin n_rsp++; if (rsp_at == 0) rsp_at = c; end
      if (req_ready[i]) rdy_at = c;
      if (!ramoe[i]) n_oe++;
      if (!ramwe[i]) begin n_we++; if (dat_out[i] !== nw) bad_dat++; end
      if (dat_oe[i]) n_doe++;
      if (!ramcs[i] && adr[i] !== a) bad_adr++;
    end
    if (!we) begin
      e_lat = w + 1; e_oe = w; e_we = 0; e_doe = 0; exp_rdata[i] = old;
    end else if (be == 2'b11) begin
      e_lat = w + 3; e_oe = 0; e_we = w; e_doe = w + 2;
    end else if (be == 2'b00) begin
      e_lat = 1; e_oe = 0; e_we = 0; e_doe = 0;
    end else begin
      e_lat = 2 * w + 3; e_oe = w; e_we = w; e_doe = w + 2;
    end
    check({tg, " rsp_cycle"}, rsp_at, e_lat);
    check({tg, " ready_cycle"}, rdy_at, e_lat + t);
    check({tg, " rsp_count"}, n_rsp, 32'd1);
    check({tg, " oe_width"}, n_oe, e_oe);
    check({tg, " we_width"}, n_we, e_we);
    check({tg, " dat_oe_width"}, n_doe, e_doe);
    check({tg, " adr_stable"}, bad_adr, 32'd0);
    check({tg, " wdata"}, bad_dat, 32'd0);
    check({tg, " rdata"}, 32'(rsp_rdata[i]), 32'(exp_rdata[i]));
    if (we) begin
      if (be != 2'b00) ref_mem[{2'(i), a}] = nw;
      check({tg, " mem"}, 32'(sram_rd(i, a)), 32'(ref_rd(i, a)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_be[i] = 2'b00;
      req_addr[i] = '0; req_wdata[i] = '0; exp_rdata[i] = '0; inv_bad[i] = 0;
    end

    // Reset held 5 cycles; outputs idle throughout, ready one cycle after release.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0 || c == 4)
        for (int i = 0; i < N; i++)
          check($sformatf("i%0d reset c%0d cs/oe/we/oe_dat/rdy/rsp", i, c),
                32'({ramcs[i], ramoe[i], ramwe[i], dat_oe[i], req_ready[i], rsp_valid[i]}),
                32'b111000);
    end
    check("reset adr", 32'(adr[0]), 32'd0);
    check("reset rdata", 32'(rsp_rdata[0]), 32'd0);
    check("reset dat_out", 32'(dat_out[0]), 32'd0);
    reset = 1'b0;
    #1 check("ready before first edge", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("i%0d ready after reset", i), 32'(req_ready[i]), 32'd1);

    // Directed sequence on the W=2 instance.
    txn(0, 1'b1, 2'b11, 19'h12345, 16'hBEEF);
    txn(0, 1'b0, 2'b00, 19'h12345, 16'h0000);
    check("read beef", 32'(rsp_rdata[0]), 32'h0000BEEF);
    txn(0, 1'b1, 2'b01, 19'h12345, 16'h0011);
    check("rmw lane0", 32'(sram_rd(0, 19'h12345)), 32'h0000BE11);
    txn(0, 1'b1, 2'b10, 19'h12345, 16'h2200);
    check("rmw lane1", 32'(sram_rd(0, 19'h12345)), 32'h00002211);
    check("rmw rdata held", 32'(rsp_rdata[0]), 32'h0000BEEF);
    txn(0, 1'b1, 2'b00, 19'h12345, 16'hFFFF);
    check("be00 no write", 32'(sram_rd(0, 19'h12345)), 32'h00002211);
    txn(0, 1'b0, 2'b00, 19'h12345, 16'h0000);
    check("read 2211", 32'(rsp_rdata[0]), 32'h00002211);

    // Randomized traffic on all three parameter sets over a small address pool.
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 25; n++) begin
        a = 19'h40 + AW'($urandom_range(0, 5));
        txn(i, 1'($urandom_range(0, 1)), 2'($urandom), a, DW'($urandom));
      end

    // Reset in the middle of the WE-low phase of a full write.
    k_wait_ready: for (int c = 0; c < 50 && !req_ready[0]; c++) @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_be[0] = 2'b11;
    req_addr[0] = 19'h00777; req_wdata[0] = 16'h1357;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid-wr we low", 32'(ramwe[0]), 32'd0);
    #2 reset = 1'b1;
    #1 check("async reset strobes", 32'({ramcs[0], ramoe[0], ramwe[0], dat_oe[0]}), 32'b1110);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("no rsp in reset c%0d", c), 32'(rsp_valid[0]), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
    txn(0, 1'b0, 2'b00, 19'h00045, 16'h0000);
    txn(1, 1'b0, 2'b00, 19'h00042, 16'h0000);

    for (int i = 0; i < N; i++) check($sformatf("i%0d invariants", i), inv_bad[i], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
